pid_ctrl: RTL and testbench
===========================

PID_CTRL -- requirements
Module: pid_ctrl

Interface
REQ-001 The block SHALL have parameter FAST_SIM, default 0, which when 1 accelerates the soft-start timer for simulation.
REQ-002 The block SHALL have parameter P_COEFF, default 5'h09, the signed proportional gain.
REQ-003 The block SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port ptch  input  16  signed pitch error from the inertial interface.
REQ-006 The block SHALL have port ptch_rt  input  16  signed pitch rate.
REQ-007 The block SHALL have port vld  input  1  one-cycle strobe; ptch/ptch_rt are valid only in this cycle.
REQ-008 The block SHALL have port pwr_up  input  1  rider-enabled power state; gates the soft-start timer.
REQ-009 The block SHALL have port rider_off  input  1  rider absent; clears the integrator.
REQ-010 The block SHALL have port PID_cntrl  output  12  signed registered control torque to the steering/shaping math stage.
REQ-011 The block SHALL have port PID_vld  output  1  one-cycle pulse marking a new PID_cntrl value.
REQ-012 The block SHALL have port ss_tmr  output  8  unsigned soft-start scale, 0..255, consumed with PID_cntrl downstream.

Function
REQ-013 Stage 1 (cycle of vld) SHALL register err_sat = ptch saturated to 10-bit signed [-512, 511].
REQ-014 Stage 1 SHALL register D_term = -(ptch_rt >>> 6), sign-extended to 16 bits.
REQ-015 Stage 1 SHALL update an 18-bit signed integrator: integ <= integ + sign-extended saturated ptch.
REQ-016 An integrator add whose operands share a sign differing from the 18-bit result (overflow) SHALL leave integ unchanged.
REQ-017 rider_off high SHALL clear integ to 0 on the next clock, overriding any simultaneous vld accumulate.
REQ-018 Stage 2 (cycle after vld) SHALL compute sum = P_COEFF*err_sat + (integ >>> 6) + D_term in 16-bit signed, using stage-1 registered values.
REQ-019 Stage 2 SHALL register PID_cntrl = sum saturated to [12'h800, 12'h7FF] and pulse PID_vld for one cycle.
REQ-020 Latency SHALL be vld at edge N, PID_cntrl and PID_vld updated at edge N+2.
REQ-021 PID_cntrl SHALL hold its value between updates.
REQ-022 Back-to-back vld strobes SHALL each produce one result; the pipeline accepts one sample per cycle.
REQ-023 A 27-bit soft-start counter SHALL add 1 per clock (256 when FAST_SIM=1) while pwr_up=1.
REQ-024 ss_tmr SHALL equal counter[26:19].
REQ-025 The counter SHALL stop once ss_tmr = 8'hFF, with no wrap.
REQ-026 pwr_up=0 SHALL clear the counter to 0 on the next clock.
REQ-027 pwr_up SHALL NOT affect the PID datapath.

Reset
REQ-028 rst_n low SHALL immediately clear the following to 0: integ, stage-1 registers, counter, PID_cntrl, PID_vld and ss_tmr.
REQ-029 Reset asserted mid-pipeline SHALL discard the in-flight sample; no PID_vld follows deassertion until a new vld.

Verification
REQ-030 The bench SHALL cover: reset release, ptch=16'h0010, ptch_rt=0, single vld -> two cycles later PID_cntrl=12'h090, PID_vld=1 for one cycle.
REQ-031 The bench SHALL cover: from reset, ptch=16'h0010, ptch_rt=16'h0400, single vld -> PID_cntrl=12'h080.
REQ-032 The bench SHALL cover: ptch=16'h7000 -> PID_cntrl=12'h7FF; ptch=16'h8000 after rider_off clear -> PID_cntrl=12'h800.
REQ-033 The bench SHALL cover: 300 vlds at ptch=16'h7FFF -> integ stops at the last non-overflowing value, never wraps negative; then rider_off one cycle -> integ=0.
REQ-034 The bench SHALL cover: FAST_SIM=1, pwr_up=1 -> ss_tmr=8'h01 after 2048 cycles and 8'hFF after 522240 cycles, then stays 8'hFF; pwr_up=0 -> ss_tmr=0 next clock.
REQ-035 The bench SHALL cover: rst_n low one cycle after vld -> outputs 0 immediately; no PID_vld for 5 cycles after release.

Source files
------------

// File: rtl/pid_ctrl.sv
// Two-stage balance PID controller with saturating integrator, plus a soft-start
// ramp (ss_tmr) that scales the control torque downstream.
module pid_ctrl #(
  parameter bit                 FAST_SIM = 1'b0,
  parameter logic signed [4:0]  P_COEFF  = 5'h09
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] ptch,
  input  logic signed [15:0] ptch_rt,
  input  logic               vld,
  input  logic               pwr_up,
  input  logic               rider_off,
  output logic signed [11:0] PID_cntrl,
  output logic               PID_vld,
  output logic        [7:0]  ss_tmr
);

  localparam logic [26:0] SsInc = FAST_SIM ? 27'd256 : 27'd1;

  // Stage 1 state
  logic signed [9:0]  err_sat_q;
  logic signed [15:0] d_term_q;
  logic signed [17:0] integ_q;
  logic               s1_vld_q;

  // Stage 1 next-state values
  logic signed [9:0]  err_sat_d;
  logic signed [15:0] rt_shr;
  logic signed [15:0] d_term_d;
  logic signed [17:0] integ_sum;
  logic               integ_ovf;

  always_comb begin
    if (ptch > 16'sd511) begin
      err_sat_d = 10'sd511;
    end else if (ptch < -16'sd512) begin
      err_sat_d = -10'sd512;
    end else begin
      err_sat_d = ptch[9:0];
    end
    rt_shr    = ptch_rt >>> 6;
    d_term_d  = -rt_shr;
    integ_sum = integ_q + {{8{err_sat_d[9]}}, err_sat_d};
    // Same-sign operands producing an opposite-sign result means the add wrapped.
    integ_ovf = (integ_q[17] == err_sat_d[9]) && (integ_sum[17] != integ_q[17]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sat_q <= '0;
      d_term_q  <= '0;
      integ_q   <= '0;
      s1_vld_q  <= 1'b0;
    end else begin
      s1_vld_q <= vld;
      if (vld) begin
        err_sat_q <= err_sat_d;
        d_term_q  <= d_term_d;
      end
      if (rider_off) begin
        integ_q <= '0;
      end else if (vld && !integ_ovf) begin
        integ_q <= integ_sum;
      end
    end
  end

  // Stage 2: combine terms in 16-bit signed and clip to the 12-bit output range
  logic signed [15:0] p_coeff_ext;
  logic signed [15:0] err_ext;
  logic signed [15:0] p_term;
  logic signed [17:0] integ_shr;
  logic signed [15:0] sum;
  logic signed [11:0] cntrl_d;

  always_comb begin
    p_coeff_ext = {{11{P_COEFF[4]}}, P_COEFF};
    err_ext     = {{6{err_sat_q[9]}}, err_sat_q};
    p_term      = p_coeff_ext * err_ext;
    integ_shr   = integ_q >>> 6;
    sum         = p_term + integ_shr[15:0] + d_term_q;
    if (sum > 16'sd2047) begin
      cntrl_d = 12'sh7FF;
    end else if (sum < -16'sd2048) begin
      cntrl_d = 12'sh800;
    end else begin
      cntrl_d = sum[11:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PID_cntrl <= '0;
      PID_vld   <= 1'b0;
    end else begin
      PID_vld <= s1_vld_q;
      if (s1_vld_q) begin
        PID_cntrl <= cntrl_d;
      end
    end
  end

  // Soft-start ramp: saturates at ss_tmr == 8'hFF instead of wrapping
  logic [26:0] ss_cnt_q;
  logic [26:0] ss_cnt_d;

  always_comb begin
    ss_cnt_d = ss_cnt_q;
    if (!pwr_up) begin
      ss_cnt_d = '0;
    end else if (ss_cnt_q[26:19] != 8'hFF) begin
      ss_cnt_d = ss_cnt_q + SsInc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_cnt_q <= '0;
    end else begin
      ss_cnt_q <= ss_cnt_d;
    end
  end

  assign ss_tmr = ss_cnt_q[26:19];

endmodule

// File: tb/tb_pid_ctrl.sv
// Scoreboard bench for pid_ctrl: a behavioural model predicts each PID_cntrl value
// when a sample is driven; the monitor pops and compares on every PID_vld pulse.
module tb_pid_ctrl;

  logic               clk;
  logic               rst_n;
  logic signed [15:0] ptch;
  logic signed [15:0] ptch_rt;
  logic               vld;
  logic               pwr_up;
  logic               rider_off;
  logic signed [11:0] PID_cntrl;
  logic               PID_vld;
  logic        [7:0]  ss_tmr;

  pid_ctrl #(
    .FAST_SIM (1'b1),
    .P_COEFF  (5'h09)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ptch      (ptch),
    .ptch_rt   (ptch_rt),
    .vld       (vld),
    .pwr_up    (pwr_up),
    .rider_off (rider_off),
    .PID_cntrl (PID_cntrl),
    .PID_vld   (PID_vld),
    .ss_tmr    (ss_tmr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int m_integ = 0;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Monitor: every PID_vld pulse must match the oldest outstanding prediction
  always @(negedge clk) begin
    if (rst_n && PID_vld) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pid_vld", 1, 0);
      end else begin
        check("pid_cntrl", PID_cntrl, exp_q.pop_front());
      end
    end
  end

  // Drive one vld strobe (called at the drive phase, #1 after a rising edge)
  task automatic sample(input logic signed [15:0] p, input logic signed [15:0] rt,
                        input logic roff);
    int e;
    int d;
    int s;
    ptch      = p;
    ptch_rt   = rt;
    vld       = 1'b1;
    rider_off = roff;
    e = clamp(int'(p), -512, 511);
    d = -(int'(rt) >>> 6);
    if (roff) begin
      m_integ = 0;
    end else begin
      s = m_integ + e;
      if (s <= 131071 && s >= -131072) m_integ = s;
    end
    exp_q.push_back(clamp(9 * e + (m_integ >>> 6) + d, -2048, 2047));
    @(posedge clk);
    #1;
    vld       = 1'b0;
    rider_off = 1'b0;
  endtask

  task automatic clear_integ();
    rider_off = 1'b1;
    m_integ   = 0;
    @(posedge clk);
    #1;
    rider_off = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_pid_cntrl", PID_cntrl, 0);
    check("rst_pid_vld", PID_vld, 0);
    check("rst_ss_tmr", ss_tmr, 0);
    exp_q.delete();
    m_integ = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pv;
    int rv;
    rst_n     = 1'b0;
    ptch      = '0;
    ptch_rt   = '0;
    vld       = 1'b0;
    pwr_up    = 1'b0;
    rider_off = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Proportional only: 9 * 16 = 144
    sample(16'sh0010, 16'sh0000, 1'b0);
    check("vld_low_at_n1", PID_vld, 0);
    @(posedge clk);
    #1;
    check("vld_high_at_n2", PID_vld, 1);
    check("cntrl_090", PID_cntrl, 12'sh090);
    @(posedge clk);
    #1;
    check("vld_one_cycle", PID_vld, 0);
    repeat (3) @(posedge clk);
    #1;
    check("cntrl_hold", PID_cntrl, 12'sh090);
    drain();

    // Derivative term: 144 - (1024 >>> 6) = 128
    do_reset();
    sample(16'sh0010, 16'sh0400, 1'b0);
    drain();
    check("cntrl_080", PID_cntrl, 12'sh080);

    // Output saturation both ways
    sample(16'sh7000, 16'sh0000, 1'b0);
    drain();
    check("cntrl_sat_pos", PID_cntrl, 12'sh7FF);
    clear_integ();
    sample(16'sh8000, 16'sh0000, 1'b0);
    drain();
    check("cntrl_sat_neg", PID_cntrl, 12'sh800);

    // Back-to-back random samples, one with simultaneous rider_off
    clear_integ();
    for (int i = 0; i < 24; i++) begin
      pv = int'($urandom_range(0, 4095)) - 2048;
      rv = int'($urandom_range(0, 40000)) - 20000;
      sample(16'(pv), 16'(rv), (i == 12));
    end
    drain();

    // Integrator overflow guard: stops at 256 * 511, never wraps
    clear_integ();
    for (int i = 0; i < 300; i++) sample(16'sh7FFF, 16'sh0000, 1'b0);
    drain();
    check("integ_sat_model", dut.integ_q, m_integ);
    check("integ_sat_value", dut.integ_q, 130816);
    clear_integ();
    check("integ_cleared", dut.integ_q, 0);

    // Reset with a sample in stage 1
    ptch = 16'sh0100;
    ptch_rt = 16'sh0000;
    vld = 1'b1;
    @(posedge clk);
    #1;
    vld = 1'b0;
    check("pre_rst_cntrl_nonzero", (PID_cntrl != 0), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_pid_cntrl", PID_cntrl, 0);
    check("midrst_pid_vld", PID_vld, 0);
    check("midrst_integ", dut.integ_q, 0);
    exp_q.delete();
    m_integ = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_vld_after_rst", PID_vld, 0);
    end
    @(posedge clk);
    #1;

    // Soft-start ramp with FAST_SIM (256 per clock)
    check("ss_idle", ss_tmr, 0);
    pwr_up = 1'b1;
    repeat (2047) @(posedge clk);
    #1;
    check("ss_before_01", ss_tmr, 8'h00);
    @(posedge clk);
    #1;
    check("ss_01", ss_tmr, 8'h01);
    repeat (522240 - 2048 - 1) @(posedge clk);
    #1;
    check("ss_fe", ss_tmr, 8'hFE);
    @(posedge clk);
    #1;
    check("ss_ff", ss_tmr, 8'hFF);
    repeat (50) @(posedge clk);
    #1;
    check("ss_ff_held", ss_tmr, 8'hFF);
    check("ss_cnt_no_wrap", dut.ss_cnt_q, 27'h7F80000);
    pwr_up = 1'b0;
    @(posedge clk);
    #1;
    check("ss_cleared", ss_tmr, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
